// File: rtl/regbank_init_sequencer_if.sv
// Bundle between the sequencer, the host preload stream and the register-bank
// init write port.
//   ld_valid/ld_addr/ld_data/ld_last : preload beat from host (master -> slave)
//   ld_ready                         : preload beat accepted (slave -> master)
//   sel                              : 0 = init port owns bank, 1 = core owns bank
//   dirIniciar/escribir/EWIniciar    : init-port address, data, active-low write enable
interface regbank_init_sequencer_if;
    logic        ld_valid;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        sel;
    logic [4:0]  dirIniciar;
    logic [31:0] escribir;
    logic        EWIniciar;

    // Host / bench side: drives the preload stream, observes the bank port.
    modport master (
        output ld_valid, ld_addr, ld_data, ld_last,
        input  ld_ready, sel, dirIniciar, escribir, EWIniciar
    );

    // Sequencer side.
    modport slave (
        input  ld_valid, ld_addr, ld_data, ld_last,
        output ld_ready, sel, dirIniciar, escribir, EWIniciar
    );
endinterface

// File: rtl/regbank_init_sequencer.sv
// Register-bank init sequencer for the single-cycle MIPS core.
// Clears every bank entry, optionally preloads entries from a valid/ready
// stream, then hands the bank to the core and gates stepping for a bounded
// number of cycles; freezes the core and reports done on limit or halt.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   i_start           : begin a sequence (honoured in IDLE/HALT only)
//   i_preload_en      : sampled with start, enables the LOAD phase
//   i_run_limit       : RUN cycles allowed, sampled with start (0 = unbounded)
//   i_halt_req        : stop request, honoured in RUN only
//   bus               : preload stream + init write port (slave modport)
//   o_cpu_en          : core step enable
//   o_busy            : sequence in progress
//   o_done            : run finished, held until next start
//   o_cycle_count     : RUN cycles elapsed (saturating)
module regbank_init_sequencer #(
    parameter int unsigned NUM_REGS    = 32,
    parameter logic [31:0] CLEAR_VALUE = 32'h0000_0000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic                          i_preload_en,
    input  logic [CNT_W-1:0]              i_run_limit,
    input  logic                          i_halt_req,
    regbank_init_sequencer_if.slave       bus,
    output logic                          o_cpu_en,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [CNT_W-1:0]              o_cycle_count
);

    localparam int unsigned ADDR_W   = 5;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_LDRAIN,
        S_RUN,
        S_HALT
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_idx;
    logic                r_preload;
    logic [CNT_W-1:0]    r_run_limit;
    logic [CNT_W-1:0]    r_cycle_count;
    logic                r_sel;
    logic [ADDR_W-1:0]   r_dir;
    logic [31:0]         r_escribir;
    logic                r_ew_n;
    logic                r_ld_ready;
    logic                r_cpu_en;
    logic                r_busy;
    logic                r_done;

    logic                w_accept;
    logic                w_limit_hit;
    logic [CNT_W-1:0]    w_count_next;

    assign w_accept     = (r_state == S_LOAD) && r_ld_ready && bus.ld_valid;
    // Compare against limit-1 so the cycle that reaches the limit is still counted.
    assign w_limit_hit  = (r_run_limit != '0) && (r_cycle_count == r_run_limit - CNT_W'(1));
    assign w_count_next = (&r_cycle_count) ? r_cycle_count : r_cycle_count + CNT_W'(1);

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_preload     <= 1'b0;
            r_run_limit   <= '0;
            r_cycle_count <= '0;
            r_sel         <= 1'b0;
            r_dir         <= '0;
            r_escribir    <= '0;
            r_ew_n        <= 1'b1;
            r_ld_ready    <= 1'b0;
            r_cpu_en      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (i_start) begin
                        r_state       <= S_CLEAR;
                        r_idx         <= '0;
                        r_preload     <= i_preload_en;
                        r_run_limit   <= i_run_limit;
                        r_cycle_count <= '0;
                        r_sel         <= 1'b0;
                        r_dir         <= '0;
                        r_escribir    <= CLEAR_VALUE;
                        r_ew_n        <= 1'b0;
                        r_cpu_en      <= 1'b0;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (r_idx == LAST_IDX) begin
                        r_ew_n <= 1'b1;
                        if (r_preload) begin
                            r_state    <= S_LOAD;
                            r_ld_ready <= 1'b1;
                        end else begin
                            // Write enable drops in the same edge the core takes the bank.
                            r_state  <= S_RUN;
                            r_sel    <= 1'b1;
                            r_cpu_en <= 1'b1;
                        end
                    end else begin
                        r_idx <= r_idx + ADDR_W'(1);
                        r_dir <= r_idx + ADDR_W'(1);
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_dir      <= bus.ld_addr;
                        r_escribir <= bus.ld_data;
                        r_ew_n     <= 1'b0;
                        if (bus.ld_last) begin
                            r_state    <= S_LDRAIN;
                            r_ld_ready <= 1'b0;
                        end
                    end else begin
                        r_ew_n <= 1'b1;
                    end
                end
                S_LDRAIN: begin
                    // Final preload write is visible this cycle; hand over next.
                    r_state  <= S_RUN;
                    r_ew_n   <= 1'b1;
                    r_sel    <= 1'b1;
                    r_cpu_en <= 1'b1;
                end
                S_RUN: begin
                    r_cycle_count <= w_count_next;
                    if (w_limit_hit || i_halt_req) begin
                        r_state  <= S_HALT;
                        r_cpu_en <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ld_ready   = r_ld_ready;
    assign bus.sel        = r_sel;
    assign bus.dirIniciar = r_dir;
    assign bus.escribir   = r_escribir;
    assign bus.EWIniciar  = r_ew_n;
    assign o_cpu_en       = r_cpu_en;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_cycle_count  = r_cycle_count;

endmodule
